// File: rtl/uart_mmio_pkg.sv
// Shared constants for the UART MMIO bridge: register addresses, status bit
// positions and the TX sequencer state encoding.
package uart_mmio_pkg;

  localparam logic [31:0] PKG_TX_ADDR   = 32'hFF00_1000;
  localparam logic [31:0] PKG_RX_ADDR   = 32'hFF00_2000;
  localparam logic [31:0] PKG_STAT_ADDR = 32'hFF00_2004;

  localparam int STAT_RX_NONEMPTY = 0;
  localparam int STAT_TX_FULL     = 1;
  localparam int STAT_RX_OVF      = 2;
  localparam int STAT_TX_OVF      = 3;

  // Last busy-less WAIT cycle before the sequencer gives up on the handshake.
  localparam logic [1:0] TX_WAIT_LAST = 2'd1;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output. A pop on a full FIFO
// frees the slot for a push on the same edge; a pop on an empty FIFO is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{(CW-1){1'b0}}, w_do_push} - {{(CW-1){1'b0}}, w_do_pop};
    end
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// MMIO bridge between the datapath dmem port and the UART lite cores: TX/RX
// FIFOs, a sticky-overflow status register and a TX sequencer feeding txuartlite.
module uart_mmio_fifo
  import uart_mmio_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] TX_ADDR    = PKG_TX_ADDR,
  parameter logic [31:0] RX_ADDR    = PKG_RX_ADDR,
  parameter logic [31:0] STAT_ADDR  = PKG_STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_to_dmem,
  input  logic [31:0] store_data,
  input  logic [3:0]  store_we,
  input  logic        load_re,
  output logic [31:0] load_data,
  output logic        mmio_hit,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  input  logic        rx_wr,
  input  logic [7:0]  rx_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            w_wr, w_hit_tx, w_hit_rx, w_hit_stat;
  logic            w_tx_push, w_tx_pop, w_rx_pop;
  logic            w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [7:0]      w_tx_head, w_rx_head;
  logic [CW-1:0]   w_tx_count, w_rx_count;
  logic            w_tx_ovf_set, w_rx_ovf_set, w_stat_wr;
  logic            w_unused;
  tx_state_e       r_state, w_next;
  logic [7:0]      r_tx_data;
  logic            r_seen_busy;
  logic [1:0]      r_wait_cnt;
  logic            r_tx_ovf, r_rx_ovf;

  assign w_wr       = |store_we;
  assign w_hit_tx   = (addr_to_dmem == TX_ADDR);
  assign w_hit_rx   = (addr_to_dmem == RX_ADDR);
  assign w_hit_stat = (addr_to_dmem == STAT_ADDR);
  assign mmio_hit   = w_hit_tx || w_hit_rx || w_hit_stat;

  assign w_tx_push    = w_wr && w_hit_tx;
  assign w_rx_pop     = load_re && w_hit_rx && !w_rx_empty;
  assign w_stat_wr    = w_wr && w_hit_stat;
  assign w_tx_ovf_set = w_tx_push && w_tx_full && !w_tx_pop;
  assign w_rx_ovf_set = rx_wr && w_rx_full && !w_rx_pop;
  assign w_unused     = &{1'b0, store_data[31:8], w_tx_count, w_rx_count};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(w_tx_push), .i_pop(w_tx_pop),
    .i_din(store_data[7:0]), .o_dout(w_tx_head), .o_full(w_tx_full),
    .o_empty(w_tx_empty), .o_count(w_tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(rx_wr), .i_pop(w_rx_pop),
    .i_din(rx_data), .o_dout(w_rx_head), .o_full(w_rx_full),
    .o_empty(w_rx_empty), .o_count(w_rx_count)
  );

  always_comb begin
    load_data = 32'd0;
    if (w_hit_rx && !w_rx_empty) begin
      load_data = {24'd0, w_rx_head};
    end else if (w_hit_stat) begin
      load_data[STAT_TX_OVF]      = r_tx_ovf;
      load_data[STAT_RX_OVF]      = r_rx_ovf;
      load_data[STAT_TX_FULL]     = w_tx_full;
      load_data[STAT_RX_NONEMPTY] = !w_rx_empty;
    end
  end

  // Sticky flags: a set on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (w_tx_ovf_set)                              r_tx_ovf <= 1'b1;
      else if (w_stat_wr && store_data[STAT_TX_OVF]) r_tx_ovf <= 1'b0;
      if (w_rx_ovf_set)                              r_rx_ovf <= 1'b1;
      else if (w_stat_wr && store_data[STAT_RX_OVF]) r_rx_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_tx_pop = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (!w_tx_empty && !tx_busy) begin
          w_next   = TX_SEND;
          w_tx_pop = 1'b1;
        end
      end
      TX_SEND: w_next = TX_WAIT;
      TX_WAIT: begin
        // Frame done once busy was observed and dropped; give up if it never rose.
        if (r_seen_busy && !tx_busy) w_next = TX_IDLE;
        else if (!r_seen_busy && !tx_busy && r_wait_cnt == TX_WAIT_LAST) w_next = TX_IDLE;
      end
      default: w_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= TX_IDLE;
      r_tx_data   <= 8'd0;
      r_seen_busy <= 1'b0;
      r_wait_cnt  <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_tx_pop) r_tx_data <= w_tx_head;
      if (r_state == TX_WAIT && w_next == TX_WAIT) begin
        if (tx_busy) r_seen_busy <= 1'b1;
        r_wait_cnt <= r_wait_cnt + 2'd1;
      end else begin
        r_seen_busy <= 1'b0;
        r_wait_cnt  <= 2'd0;
      end
    end
  end

  assign tx_wr   = (r_state == TX_SEND);
  assign tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Bench for uart_mmio_fifo: queue-based model of both FIFOs and sticky flags,
// a txuartlite busy model, and one task per scenario.
module tb_uart_mmio_fifo;

  localparam int          DEPTH     = 16;
  localparam logic [31:0] TX_ADDR   = 32'hFF00_1000;
  localparam logic [31:0] RX_ADDR   = 32'hFF00_2000;
  localparam logic [31:0] STAT_ADDR = 32'hFF00_2004;
  localparam logic [31:0] NO_ADDR   = 32'h0000_1234;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr_to_dmem = '0;
  logic [31:0] store_data = '0;
  logic [3:0]  store_we = '0;
  logic        load_re = 1'b0;
  logic [31:0] load_data;
  logic        mmio_hit;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy = 1'b0;
  logic        rx_wr = 1'b0;
  logic [7:0]  rx_data = '0;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int tx_seen = 0;
  int busy_cnt = 0;
  bit force_busy = 1'b0;

  logic [7:0]  tx_exp_q[$];
  logic [7:0]  rx_q[$];
  bit          m_tx_ovf = 1'b0;
  bit          m_rx_ovf = 1'b0;
  logic [31:0] ld;

  uart_mmio_fifo dut (
    .clk(clk), .rst_n(rst_n), .addr_to_dmem(addr_to_dmem), .store_data(store_data),
    .store_we(store_we), .load_re(load_re), .load_data(load_data), .mmio_hit(mmio_hit),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy), .rx_wr(rx_wr), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // txuartlite stand-in and TX scoreboard: busy rises the cycle after tx_wr.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (tx_wr === 1'b1) begin
        chk_cnt++;
        if (tx_busy !== 1'b0) $display("FAIL tx_wr_overlap: tx_busy=%0b required 0", tx_busy);
        else pass_cnt++;
        chk_cnt++;
        if (tx_exp_q.size() == 0) begin
          $display("FAIL tx_unexpected: tx_wr with tx_data=%02h, none required", tx_data);
        end else begin
          exp_b = tx_exp_q.pop_front();
          if (tx_data !== exp_b) $display("FAIL tx_data: got %02h required %02h", tx_data, exp_b);
          else pass_cnt++;
        end
        tx_seen++;
      end
      tx_busy = force_busy || (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      if (tx_wr === 1'b1) busy_cnt = 10;
    end
  end

  function automatic logic [31:0] exp_stat();
    return {28'd0, m_tx_ovf, m_rx_ovf, 1'(tx_exp_q.size() == DEPTH), 1'(rx_q.size() != 0)};
  endfunction

  task automatic cyc(input logic [31:0] a, input logic [3:0] we, input logic [31:0] sd,
                     input logic re, input logic rw, input logic [7:0] rd);
    @(negedge clk);
    addr_to_dmem = a; store_we = we; store_data = sd;
    load_re = re; rx_wr = rw; rx_data = rd;
    #1 ld = load_data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(NO_ADDR, 4'h0, 32'd0, 1'b0, 1'b0, 8'd0);
  endtask

  // Model an RX push/pop edge: pop first (if non-empty), then the push.
  task automatic model_rx(input logic re, input logic rw, input logic [7:0] rd);
    bit popped;
    popped = re && (rx_q.size() != 0);
    if (popped) void'(rx_q.pop_front());
    if (rw) begin
      if (rx_q.size() == DEPTH) m_rx_ovf = 1'b1;
      else rx_q.push_back(rd);
    end
  endtask

  task automatic model_tx_push(input logic [7:0] b);
    if (tx_exp_q.size() == DEPTH) m_tx_ovf = 1'b1;
    else tx_exp_q.push_back(b);
  endtask

  task automatic read_stat(output logic [31:0] v);
    cyc(STAT_ADDR, 4'h0, 32'd0, 1'b0, 1'b0, 8'd0);
    v = ld;
  endtask

  task automatic wait_tx(input int target, input int budget, input string name);
    int n = 0;
    while (tx_seen < target && n < budget) begin idle(1); n++; end
    chk_cnt++;
    if (tx_seen < target) $display("FAIL %s: tx_wr count %0d required %0d", name, tx_seen, target);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0; rx_wr = 1'b1; rx_data = 8'h77; addr_to_dmem = STAT_ADDR;
    repeat (3) @(negedge clk);
    #1;
    chk_cnt++; if (tx_wr !== 1'b0) $display("FAIL rst_tx_wr: got %0b required 0", tx_wr); else pass_cnt++;
    chk_cnt++; if (tx_data !== 8'd0) $display("FAIL rst_tx_data: got %02h required 00", tx_data); else pass_cnt++;
    chk_cnt++; if (load_data !== 32'd0) $display("FAIL rst_stat: got %08h required 0", load_data); else pass_cnt++;
    chk_cnt++; if (mmio_hit !== 1'b1) $display("FAIL rst_hit: got %0b required 1", mmio_hit); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1; rx_wr = 1'b0;
    cyc(RX_ADDR, 4'h0, 32'd0, 1'b0, 1'b0, 8'd0);
    chk_cnt++; if (ld !== 32'd0) $display("FAIL rst_rx_read: got %08h required 0", ld); else pass_cnt++;
    read_stat(v);
    chk_cnt++; if (v !== exp_stat()) $display("FAIL post_rst_stat: got %08h required %08h", v, exp_stat()); else pass_cnt++;
    cyc(NO_ADDR, 4'h0, 32'd0, 1'b0, 1'b0, 8'd0);
    chk_cnt++; if (mmio_hit !== 1'b0 || ld !== 32'd0)
      $display("FAIL nohit: hit=%0b data=%08h required 0/0", mmio_hit, ld); else pass_cnt++;
    cyc(TX_ADDR, 4'h0, 32'd0, 1'b0, 1'b0, 8'd0);
    chk_cnt++; if (mmio_hit !== 1'b1 || ld !== 32'd0)
      $display("FAIL tx_addr_read: hit=%0b data=%08h required 1/0", mmio_hit, ld); else pass_cnt++;
    idle(1);
  endtask

  task automatic test_tx_back_to_back();
    logic [7:0] bytes[3] = '{8'h41, 8'h42, 8'h43};
    int start = tx_seen;
    foreach (bytes[i]) begin
      cyc(TX_ADDR, 4'hF, {24'd0, bytes[i]}, 1'b0, 1'b0, 8'd0);
      model_tx_push(bytes[i]);
    end
    idle(1);
    wait_tx(start + 3, 200, "tx_b2b_count");
    idle(15);
    chk_cnt++; if (tx_exp_q.size() != 0) $display("FAIL tx_b2b_left: %0d bytes pending required 0", tx_exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_tx_overflow();
    logic [31:0] v;
    logic [7:0]  b;
    int start = tx_seen;
    force_busy = 1'b1;
    idle(2);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      cyc(TX_ADDR, 4'h1, {24'hABCDEF, b}, 1'b0, 1'b0, 8'd0);
      model_tx_push(b);
    end
    read_stat(v);
    chk_cnt++; if (v !== exp_stat() || v !== 32'hA) $display("FAIL tx_ovf_stat: got %08h required %08h", v, exp_stat()); else pass_cnt++;
    cyc(STAT_ADDR, 4'hF, 32'h8, 1'b0, 1'b0, 8'd0);
    m_tx_ovf = 1'b0;
    read_stat(v);
    chk_cnt++; if (v !== exp_stat()) $display("FAIL tx_ovf_clear: got %08h required %08h", v, exp_stat()); else pass_cnt++;
    force_busy = 1'b0;
    idle(1);
    wait_tx(start + DEPTH, DEPTH * 20 + 50, "tx_drain_count");
    idle(15);
    read_stat(v);
    chk_cnt++; if (v !== exp_stat()) $display("FAIL tx_drain_stat: got %08h required %08h", v, exp_stat()); else pass_cnt++;
  endtask

  task automatic rx_read_check(input string name);
    logic [31:0] e;
    e = (rx_q.size() != 0) ? {24'd0, rx_q[0]} : 32'd0;
    cyc(RX_ADDR, 4'h0, 32'd0, 1'b1, 1'b0, 8'd0);
    chk_cnt++; if (ld !== e) $display("FAIL %s: got %08h required %08h", name, ld, e); else pass_cnt++;
    model_rx(1'b1, 1'b0, 8'd0);
  endtask

  task automatic test_rx_basic();
    logic [31:0] v;
    cyc(NO_ADDR, 4'h0, 32'd0, 1'b0, 1'b1, 8'h5A); model_rx(1'b0, 1'b1, 8'h5A);
    cyc(NO_ADDR, 4'h0, 32'd0, 1'b0, 1'b1, 8'hA5); model_rx(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) rx_read_check("rx_basic_read");
    read_stat(v);
    chk_cnt++; if (v !== exp_stat() || v[0] !== 1'b0) $display("FAIL rx_basic_stat: got %08h required %08h", v, exp_stat()); else pass_cnt++;
  endtask

  task automatic test_rx_full_pop();
    logic [31:0] v, e;
    logic [7:0]  b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      cyc(NO_ADDR, 4'h0, 32'd0, 1'b0, 1'b1, b); model_rx(1'b0, 1'b1, b);
    end
    b = 8'($urandom_range(0, 255));
    e = {24'd0, rx_q[0]};
    cyc(RX_ADDR, 4'h0, 32'd0, 1'b1, 1'b1, b);
    chk_cnt++; if (ld !== e) $display("FAIL rx_full_pop_data: got %08h required %08h", ld, e); else pass_cnt++;
    model_rx(1'b1, 1'b1, b);
    read_stat(v);
    chk_cnt++; if (v !== exp_stat() || v !== 32'h1) $display("FAIL rx_full_pop_stat: got %08h required %08h", v, exp_stat()); else pass_cnt++;
    b = 8'($urandom_range(0, 255));
    cyc(NO_ADDR, 4'h0, 32'd0, 1'b0, 1'b1, b); model_rx(1'b0, 1'b1, b);
    read_stat(v);
    chk_cnt++; if (v !== exp_stat() || v !== 32'h5) $display("FAIL rx_ovf_stat: got %08h required %08h", v, exp_stat()); else pass_cnt++;
    cyc(STAT_ADDR, 4'h2, 32'h4, 1'b0, 1'b0, 8'd0); m_rx_ovf = 1'b0;
    read_stat(v);
    chk_cnt++; if (v !== exp_stat()) $display("FAIL rx_ovf_clear: got %08h required %08h", v, exp_stat()); else pass_cnt++;
    // Clear and overflow on the same edge: the overflow must stick.
    cyc(STAT_ADDR, 4'h2, 32'h4, 1'b0, 1'b1, 8'h11); m_rx_ovf = 1'b0; model_rx(1'b0, 1'b1, 8'h11);
    read_stat(v);
    chk_cnt++; if (v !== exp_stat() || v[2] !== 1'b1) $display("FAIL rx_set_wins: got %08h required %08h", v, exp_stat()); else pass_cnt++;
    for (int i = 0; i < DEPTH + 1; i++) rx_read_check("rx_drain_read");
    cyc(STAT_ADDR, 4'h8, 32'h4, 1'b0, 1'b0, 8'd0); m_rx_ovf = 1'b0;
    read_stat(v);
    chk_cnt++; if (v !== exp_stat() || v !== 32'h0) $display("FAIL rx_end_stat: got %08h required %08h", v, exp_stat()); else pass_cnt++;
  endtask

  task automatic test_rx_random();
    logic [31:0] v, e;
    logic        rw, re;
    logic [7:0]  b;
    for (int i = 0; i < 300; i++) begin
      rw = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 2) == 0);
      b  = 8'($urandom_range(0, 255));
      e  = (rx_q.size() != 0) ? {24'd0, rx_q[0]} : 32'd0;
      cyc(RX_ADDR, 4'h0, 32'd0, re, rw, b);
      chk_cnt++; if (ld !== e) $display("FAIL rx_rand_read[%0d]: got %08h required %08h", i, ld, e); else pass_cnt++;
      model_rx(re, rw, b);
    end
    read_stat(v);
    chk_cnt++; if (v !== exp_stat()) $display("FAIL rx_rand_stat: got %08h required %08h", v, exp_stat()); else pass_cnt++;
    while (rx_q.size() != 0) rx_read_check("rx_rand_drain");
    cyc(STAT_ADDR, 4'h4, 32'hC, 1'b0, 1'b0, 8'd0); m_rx_ovf = 1'b0; m_tx_ovf = 1'b0;
    idle(1);
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] v;
    int n = 0;
    int start = tx_seen;
    for (int i = 0; i < 4; i++) begin
      cyc(TX_ADDR, 4'hF, 32'($urandom_range(0, 255)), 1'b0, 1'b0, 8'd0);
      model_tx_push(store_data[7:0]);
    end
    idle(1);
    wait_tx(start + 1, 50, "mid_tx_first");
    idle(2);
    @(negedge clk);
    rst_n = 1'b0;
    tx_exp_q.delete(); rx_q.delete(); m_tx_ovf = 1'b0; m_rx_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_cnt++; if (tx_data !== 8'd0) $display("FAIL mid_rst_tx_data: got %02h required 00", tx_data); else pass_cnt++;
    read_stat(v);
    chk_cnt++; if (v !== exp_stat()) $display("FAIL mid_rst_stat: got %08h required %08h", v, exp_stat()); else pass_cnt++;
    start = tx_seen;
    while (n < 60) begin idle(1); n++; end
    chk_cnt++; if (tx_seen != start) $display("FAIL mid_rst_no_tx: %0d tx_wr after reset required 0", tx_seen - start); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_tx_back_to_back();
    test_tx_overflow();
    test_rx_basic();
    test_rx_full_pop();
    test_rx_random();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
